// File: rtl/branch_predict_resolve_if.sv
// Purpose : Bundles the fetch-prediction, execute-resolution and statistics
//           signals of the branch unit.
// Ports   : master - pipeline side (drives PCs, flags, resolve requests)
//           slave  - branch unit side (drives prediction, outcome, counters)
interface branch_predict_resolve_if #(
   parameter int PC_W  = 16,
   parameter int CNT_W = 16
) ();
   logic [PC_W-1:0]  pred_pc;
   logic             pred_taken;
   logic             res_valid;
   logic [PC_W-1:0]  res_pc;
   logic [2:0]       res_comp_code;
   logic             res_zf;
   logic             res_lt;
   logic             res_pred_taken;
   logic             res_taken;
   logic             res_mispredict;
   logic             stat_clr;
   logic [CNT_W-1:0] stat_branches;
   logic [CNT_W-1:0] stat_mispredicts;

   modport master (
      output pred_pc, res_valid, res_pc, res_comp_code, res_zf, res_lt,
             res_pred_taken, stat_clr,
      input  pred_taken, res_taken, res_mispredict, stat_branches,
             stat_mispredicts
   );

   modport slave (
      input  pred_pc, res_valid, res_pc, res_comp_code, res_zf, res_lt,
             res_pred_taken, stat_clr,
      output pred_taken, res_taken, res_mispredict, stat_branches,
             stat_mispredicts
   );
endinterface

// File: rtl/branch_predict_resolve.sv
// Purpose : Resolves conditional branches from ALU flags, trains a table of
//           2-bit saturating predictors indexed by PC, and keeps saturating
//           branch / mispredict statistics.
// Ports   : clk, rst (synchronous, active-high)
//           bp (slave) - pred_pc -> pred_taken (combinational read),
//                        res_* -> res_taken / res_mispredict (combinational),
//                        stat_clr -> stat_branches / stat_mispredicts
module branch_predict_resolve #(
   parameter int         PC_W     = 16,
   parameter int         IDX_W    = 6,
   parameter int         IDX_LSB  = 1,
   parameter logic [1:0] INIT_CTR = 2'b01,
   parameter int         CNT_W    = 16
) (
   input logic                     clk,
   input logic                     rst,
   branch_predict_resolve_if.slave bp
);
   localparam int unsigned DEPTH = 2 ** IDX_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      CC_EQ     = 3'b000,
      CC_NE     = 3'b001,
      CC_LT     = 3'b010,
      CC_GE     = 3'b011,
      CC_LE     = 3'b100,
      CC_GT     = 3'b101,
      CC_ALWAYS = 3'b110,
      CC_NEVER  = 3'b111
   } cc_e;

   logic [1:0]       r_tbl [DEPTH];
   logic [CNT_W-1:0] r_branches;
   logic [CNT_W-1:0] r_mispredicts;

   logic [IDX_W-1:0] w_pidx;
   logic [IDX_W-1:0] w_ridx;
   logic             w_cond;
   logic             w_taken;
   logic             w_mispredict;

   assign w_pidx = bp.pred_pc[IDX_LSB +: IDX_W];
   assign w_ridx = bp.res_pc[IDX_LSB +: IDX_W];

   // Condition is evaluated unconditionally; res_valid only gates the result.
   always_comb begin
      w_cond = 1'b0;
      case (cc_e'(bp.res_comp_code))
         CC_EQ:     w_cond = bp.res_zf;
         CC_NE:     w_cond = ~bp.res_zf;
         CC_LT:     w_cond = bp.res_lt;
         CC_GE:     w_cond = bp.res_zf | ~bp.res_lt;
         CC_LE:     w_cond = bp.res_lt | bp.res_zf;
         CC_GT:     w_cond = ~bp.res_lt & ~bp.res_zf;
         CC_ALWAYS: w_cond = 1'b1;
         CC_NEVER:  w_cond = 1'b0;
         default:   w_cond = 1'b0;
      endcase
   end

   assign w_taken      = bp.res_valid & w_cond;
   assign w_mispredict = bp.res_valid & (w_taken ^ bp.res_pred_taken);

   // Read is from the registered table, so a same-cycle update on the same
   // index is not visible until the following cycle.
   assign bp.pred_taken       = r_tbl[w_pidx][1];
   assign bp.res_taken        = w_taken;
   assign bp.res_mispredict   = w_mispredict;
   assign bp.stat_branches    = r_branches;
   assign bp.stat_mispredicts = r_mispredicts;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tbl <= '{default: INIT_CTR};
      end else if (bp.res_valid) begin
         if (w_taken) begin
            if (r_tbl[w_ridx] != 2'b11) r_tbl[w_ridx] <= r_tbl[w_ridx] + 2'b01;
         end else begin
            if (r_tbl[w_ridx] != 2'b00) r_tbl[w_ridx] <= r_tbl[w_ridx] - 2'b01;
         end
      end
   end

   // Statistics saturate at all-ones; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || bp.stat_clr) begin
         r_branches    <= '0;
         r_mispredicts <= '0;
      end else begin
         if (bp.res_valid && (r_branches != '1))
            r_branches <= r_branches + CNT_ONE;
         if (w_mispredict && (r_mispredicts != '1))
            r_mispredicts <= r_mispredicts + CNT_ONE;
      end
   end
endmodule
